// File: rtl/bellek_port_hakemi_if.sv
// Request/response bundle shared by the requesters and the L1 port.
// master drives the request and takes responses; slave is the other side.
interface bellek_port_hakemi_if #(
    parameter int ADRES_BIT = 32,
    parameter int VERI_BIT  = 32,
    parameter int MASKE_BIT = VERI_BIT / 8
);
    logic [ADRES_BIT-1:0] adres;
    logic                 gecerli;
    logic                 yaz;
    logic [VERI_BIT-1:0]  veri;
    logic [MASKE_BIT-1:0] maske;
    logic                 hazir;
    logic [VERI_BIT-1:0]  yan_veri;
    logic                 yan_gecerli;
    logic                 yan_hazir;

    modport master (
        output adres, gecerli, yaz, veri, maske,
        input  hazir,
        input  yan_veri, yan_gecerli,
        output yan_hazir
    );

    modport slave (
        input  adres, gecerli, yaz, veri, maske,
        output hazir,
        output yan_veri, yan_gecerli,
        input  yan_hazir
    );
endinterface

// File: rtl/bellek_port_hakemi.sv
// Two-requester arbiter for the shared L1 port, with in-order read routing.
// Define HAKEM_SABIT_ONCELIK_EN for fixed priority (port 0 wins).
module bellek_port_hakemi #(
    parameter int ADRES_BIT    = 32,
    parameter int VERI_BIT     = 32,
    parameter int MASKE_BIT    = VERI_BIT / 8,
    parameter int MAX_BEKLEYEN = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    bellek_port_hakemi_if.slave   ist0,
    bellek_port_hakemi_if.slave   ist1,
    bellek_port_hakemi_if.master  port,
    output logic                  hata_o
);
    localparam int PW = $clog2(MAX_BEKLEYEN);
    localparam logic [PW:0] DOLU_SAY = (PW + 1)'(MAX_BEKLEYEN);

    typedef enum logic {
        BOSTA   = 1'b0,
        VERILDI = 1'b1
    } durum_t;

    durum_t durum, durum_snr;
    logic   verilen;
    logic   secim;
    logic   uygun0, uygun1;
    logic   istek_el;
    logic   itme, cekme;
    logic   bos, dolu, bas;

    logic [MAX_BEKLEYEN-1:0] kimlik;
    logic [PW-1:0]           yaz_ptr, oku_ptr;
    logic [PW:0]             sayac;

    logic [ADRES_BIT-1:0] s_adres;
    logic                 s_gecerli;
    logic                 s_yaz;
    logic [VERI_BIT-1:0]  s_veri;
    logic [MASKE_BIT-1:0] s_maske;

    assign bos  = (sayac == '0);
    assign dolu = (sayac == DOLU_SAY);
    assign bas  = kimlik[oku_ptr];

    // A full ID FIFO only blocks reads; writes need no slot.
    assign uygun0 = ist0.gecerli & (ist0.yaz | ~dolu);
    assign uygun1 = ist1.gecerli & (ist1.yaz | ~dolu);

    assign istek_el = (durum == VERILDI) & s_gecerli & port.hazir;
    assign itme     = istek_el & ~s_yaz;
    assign cekme    = ~bos & port.yan_gecerli & port.yan_hazir;

`ifdef HAKEM_SABIT_ONCELIK_EN
    assign secim = ~uygun0;
`else
    logic rr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr <= 1'b0;
        end else if (istek_el) begin
            rr <= ~verilen;
        end
    end

    assign secim = (uygun0 & uygun1) ? rr : uygun1;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum   <= BOSTA;
            verilen <= 1'b0;
        end else begin
            durum <= durum_snr;
            if (durum == BOSTA && (uygun0 | uygun1)) begin
                verilen <= secim;
            end
        end
    end

    always_comb begin
        durum_snr = durum;
        unique case (durum)
            BOSTA:   if (uygun0 | uygun1) durum_snr = VERILDI;
            VERILDI: if (istek_el) durum_snr = BOSTA;
            default: durum_snr = BOSTA;
        endcase
    end

    always_comb begin
        s_adres   = '0;
        s_gecerli = 1'b0;
        s_yaz     = 1'b0;
        s_veri    = '0;
        s_maske   = '0;
        ist0.hazir = 1'b0;
        ist1.hazir = 1'b0;
        if (durum == VERILDI) begin
            if (verilen) begin
                s_adres    = ist1.adres;
                s_gecerli  = ist1.gecerli;
                s_yaz      = ist1.yaz;
                s_veri     = ist1.veri;
                s_maske    = ist1.maske;
                ist1.hazir = port.hazir;
            end else begin
                s_adres    = ist0.adres;
                s_gecerli  = ist0.gecerli;
                s_yaz      = ist0.yaz;
                s_veri     = ist0.veri;
                s_maske    = ist0.maske;
                ist0.hazir = port.hazir;
            end
        end
    end

    assign port.adres   = s_adres;
    assign port.gecerli = s_gecerli;
    assign port.yaz     = s_yaz;
    assign port.veri    = s_veri;
    assign port.maske   = s_maske;

    // With no owner on record the response is drained (except under reset).
    always_comb begin
        ist0.yan_veri    = '0;
        ist0.yan_gecerli = 1'b0;
        ist1.yan_veri    = '0;
        ist1.yan_gecerli = 1'b0;
        port.yan_hazir   = ~rst_i;
        if (!bos) begin
            if (bas) begin
                ist1.yan_veri    = port.yan_veri;
                ist1.yan_gecerli = port.yan_gecerli;
                port.yan_hazir   = ist1.yan_hazir;
            end else begin
                ist0.yan_veri    = port.yan_veri;
                ist0.yan_gecerli = port.yan_gecerli;
                port.yan_hazir   = ist0.yan_hazir;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            kimlik  <= '0;
            yaz_ptr <= '0;
            oku_ptr <= '0;
            sayac   <= '0;
        end else begin
            if (itme) begin
                kimlik[yaz_ptr] <= verilen;
                yaz_ptr         <= yaz_ptr + 1'b1;
            end
            if (cekme) begin
                oku_ptr <= oku_ptr + 1'b1;
            end
            if (itme & ~cekme) begin
                sayac <= sayac + 1'b1;
            end else if (~itme & cekme) begin
                sayac <= sayac - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hata_o <= 1'b0;
        end else if (bos & port.yan_gecerli & port.yan_hazir) begin
            hata_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bellek_port_hakemi.sv
// Bench for bellek_port_hakemi: reset/drain table, directed corner
// sequences and a randomized run checked by a transaction scoreboard.
module tb_bellek_port_hakemi;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hata;
    int   checks = 0;
    int   failures = 0;

    bellek_port_hakemi_if i0 ();
    bellek_port_hakemi_if i1 ();
    bellek_port_hakemi_if p ();

    bellek_port_hakemi dut (
        .clk_i (clk),
        .rst_i (rst),
        .ist0  (i0),
        .ist1  (i1),
        .port  (p),
        .hata_o(hata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic g0;
        logic g1;
        logic pvg;
        logic yh0;
        logic yh1;
        logic e_pvh;
        logic e_hata;
    } vek_t;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bosalt();
        i0.gecerli = 0; i0.yaz = 0; i0.adres = 0;
        i0.veri = 0; i0.maske = 0; i0.yan_hazir = 0;
        i1.gecerli = 0; i1.yaz = 0; i1.adres = 0;
        i1.veri = 0; i1.maske = 0; i1.yan_hazir = 0;
        p.hazir = 0; p.yan_gecerli = 0; p.yan_veri = 0;
    endtask

    task automatic do_reset();
        bosalt();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic bekle_el(input string nm, output bit ok);
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (p.gecerli && p.hazir) begin
                ok = 1;
                break;
            end
            step();
        end
        chk(nm, ok, 1);
    endtask

    function automatic logic [31:0] hsh(input logic [31:0] a);
        return a ^ 32'h5A5A_F00F;
    endfunction

    vek_t tablo[10];
    int   kazanan[$];
    bit   ok;
    bit   sahip3[3];

    bit          akt[2], c_yaz[2], hs[2];
    logic [31:0] c_adres[2], c_veri[2];
    logic [3:0]  c_maske[2];
    int          bekle[2];
    int          enuzun;
    bit          own_q[$];
    logic [31:0] l1_q[$];
    bit          yanit;
    bit          sahip;
    int          n;

    initial begin
        bosalt();
        rst = 1;
        //          rst g0 g1 pvg yh0 yh1 pvh hata
        tablo[0] = '{1, 1, 1, 1, 1, 1, 0, 0};
        tablo[1] = '{1, 0, 0, 0, 0, 0, 0, 0};
        tablo[2] = '{1, 1, 0, 1, 0, 1, 0, 0};
        tablo[3] = '{0, 0, 0, 0, 1, 1, 1, 0};
        tablo[4] = '{0, 0, 0, 0, 0, 0, 1, 0};
        tablo[5] = '{0, 0, 0, 1, 0, 0, 1, 0};
        tablo[6] = '{0, 0, 0, 0, 1, 0, 1, 1};
        tablo[7] = '{0, 0, 0, 1, 0, 1, 1, 1};
        tablo[8] = '{1, 0, 0, 1, 1, 1, 0, 0};
        tablo[9] = '{0, 0, 0, 0, 0, 0, 1, 0};
        p.hazir = 1;
        for (int k = 0; k < 10; k++) begin
            step();
            rst = tablo[k].rst;
            i0.gecerli = tablo[k].g0;
            i1.gecerli = tablo[k].g1;
            p.yan_gecerli = tablo[k].pvg;
            p.yan_veri = 32'hDEAD_0000 + k;
            i0.yan_hazir = tablo[k].yh0;
            i1.yan_hazir = tablo[k].yh1;
            @(negedge clk);
            chk($sformatf("tbl%0d_pvh", k), p.yan_hazir, tablo[k].e_pvh);
            chk($sformatf("tbl%0d_hata", k), hata, tablo[k].e_hata);
            chk($sformatf("tbl%0d_yg", k),
                {i0.yan_gecerli, i1.yan_gecerli}, 2'b00);
            chk($sformatf("tbl%0d_istek", k),
                {p.gecerli, i0.hazir, i1.hazir}, 3'b000);
        end

        // Alternating grants, then full FIFO, write bypass, routing
        do_reset();
        p.hazir = 1;
        i0.yan_hazir = 1; i1.yan_hazir = 1;
        i0.adres = 32'h100; i1.adres = 32'h200;
        i0.gecerli = 1; i1.gecerli = 1;
        for (int c = 0; c < 30 && kazanan.size() < 4; c++) begin
            @(negedge clk);
            if (i0.gecerli && i0.hazir) kazanan.push_back(0);
            if (i1.gecerli && i1.hazir) kazanan.push_back(1);
            step();
        end
        chk("t2_sayi", kazanan.size(), 4);
        foreach (kazanan[k])
            chk($sformatf("t2_kazanan%0d", k), kazanan[k], k % 2);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t4_dolu_okuma", p.gecerli, 0);
            step();
        end
        i1.yaz = 1; i1.adres = 32'h300;
        i1.veri = 32'h1234; i1.maske = 4'hF;
        bekle_el("t4_yaz_zaman", ok);
        chk("t4_yaz_port", i1.hazir, 1);
        chk("t4_yaz_adres", p.adres, 32'h300);
        chk("t4_yaz_bilgi", {p.yaz, p.maske, p.veri}, {1'b1, 4'hF, 32'h1234});
        step();
        i1.gecerli = 0; i1.yaz = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t4_dolu_bekle", p.gecerli, 0);
            step();
        end
        p.yan_gecerli = 1; p.yan_veri = 32'hAAAA;
        @(negedge clk);
        chk("t3_yan0_gecerli", {i0.yan_gecerli, i1.yan_gecerli}, 2'b10);
        chk("t3_yan0_veri", i0.yan_veri, 32'hAAAA);
        chk("t3_yan0_hazir", p.yan_hazir, 1);
        step();
        p.yan_gecerli = 0;
        @(negedge clk);
        chk("t3_yan0_tek", i0.yan_gecerli, 0);
        step();
        bekle_el("t4_okuma_devam", ok);
        chk("t4_okuma_port", i0.hazir, 1);
        step();
        i0.gecerli = 0;
        p.yan_gecerli = 1; p.yan_veri = 32'hBBBB;
        @(negedge clk);
        chk("t3_yan1_gecerli", {i0.yan_gecerli, i1.yan_gecerli}, 2'b01);
        chk("t3_yan1_veri", i1.yan_veri, 32'hBBBB);
        step();
        p.yan_gecerli = 0;
        @(negedge clk);
        chk("t3_yan1_tek", i1.yan_gecerli, 0);
        step();
        sahip3 = '{0, 1, 0};
        for (int k = 0; k < 3; k++) begin
            p.yan_gecerli = 1; p.yan_veri = 32'hC0 + k;
            @(negedge clk);
            chk($sformatf("bosalt%0d_g", k),
                {i0.yan_gecerli, i1.yan_gecerli},
                sahip3[k] ? 2'b01 : 2'b10);
            chk($sformatf("bosalt%0d_v", k),
                sahip3[k] ? i1.yan_veri : i0.yan_veri, 32'hC0 + k);
            step();
        end
        p.yan_gecerli = 0;
        @(negedge clk);
        chk("bosalt_hata", hata, 0);
        chk("bosalt_drain", p.yan_hazir, 1);
        step();

        // Grant held while L1 stalls
        do_reset();
        i0.adres = 32'h400; i0.gecerli = 1;
        bekle_hazir: for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (p.gecerli) break;
            step();
        end
        chk("t5_verildi", p.gecerli, 1);
        step();
        i1.adres = 32'h500; i1.gecerli = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t5_tut", {p.gecerli, i0.hazir, i1.hazir}, 3'b100);
            chk("t5_adres", p.adres, 32'h400);
            step();
        end
        p.hazir = 1;
        @(negedge clk);
        chk("t5_el", {i0.hazir, i1.hazir}, 2'b10);
        step();
        i0.gecerli = 0;
        bekle_el("t5_sonraki", ok);
        chk("t5_sonraki_adres", p.adres, 32'h500);
        chk("t5_sonraki_port", i1.hazir, 1);
        step();
        i1.gecerli = 0; p.hazir = 0;

        // Reset with reads outstanding; late response is drained
        rst = 1;
        p.yan_gecerli = 1; p.yan_veri = 32'h77;
        i0.yan_hazir = 1; i1.yan_hazir = 1;
        @(negedge clk);
        chk("rst_orta_cikis",
            {p.yan_hazir, i0.yan_gecerli, i1.yan_gecerli, hata}, 4'b0000);
        step();
        rst = 0;
        @(negedge clk);
        chk("rst_orta_drain", {p.yan_hazir, i0.yan_gecerli, i1.yan_gecerli},
            3'b100);
        step();
        p.yan_gecerli = 0;
        @(negedge clk);
        chk("rst_orta_hata", hata, 1);
        step();
        @(negedge clk);
        chk("rst_orta_yapiskan", hata, 1);

        // Randomized run against a transaction-level scoreboard
        do_reset();
        akt = '{0, 0};
        bekle = '{0, 0};
        enuzun = 0;
        yanit = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            hs[0] = i0.gecerli && i0.hazir;
            hs[1] = i1.gecerli && i1.hazir;
            chk("rnd_tek_hazir", i0.hazir & i1.hazir, 0);
            chk("rnd_el", p.gecerli && p.hazir, hs[0] | hs[1]);
            if (hs[0] | hs[1]) begin
                n = hs[1] ? 1 : 0;
                chk("rnd_adres", p.adres, c_adres[n]);
                chk("rnd_yaz", p.yaz, c_yaz[n]);
                if (c_yaz[n]) begin
                    chk("rnd_veri", {p.maske, p.veri}, {c_maske[n], c_veri[n]});
                end else begin
                    own_q.push_back(n[0]);
                    l1_q.push_back(p.adres);
                    chk("rnd_bekleyen", own_q.size() <= 4, 1);
                end
            end
            if (yanit) begin
                sahip = own_q[0];
                chk("rnd_yan_hazir", p.yan_hazir,
                    sahip ? i1.yan_hazir : i0.yan_hazir);
                chk("rnd_yan_g", {i0.yan_gecerli, i1.yan_gecerli},
                    sahip ? 2'b01 : 2'b10);
                chk("rnd_yan_v", sahip ? i1.yan_veri : i0.yan_veri,
                    hsh(l1_q[0]));
                if (p.yan_hazir) begin
                    void'(own_q.pop_front());
                    void'(l1_q.pop_front());
                    yanit = 0;
                end
            end else begin
                chk("rnd_yan_yok", i0.yan_gecerli | i1.yan_gecerli, 0);
            end
            for (int m = 0; m < 2; m++) begin
                if (akt[m] && !hs[m]) bekle[m]++;
                else bekle[m] = 0;
                if (bekle[m] > enuzun) enuzun = bekle[m];
            end
            step();
            for (int m = 0; m < 2; m++) begin
                if (hs[m]) akt[m] = 0;
                if (!akt[m] && $urandom_range(2) == 0) begin
                    akt[m] = 1;
                    c_adres[m] = $urandom;
                    c_veri[m] = $urandom;
                    c_maske[m] = 4'($urandom);
                    c_yaz[m] = ($urandom_range(2) == 0);
                end
            end
            i0.gecerli = akt[0]; i0.adres = c_adres[0]; i0.yaz = c_yaz[0];
            i0.veri = c_veri[0]; i0.maske = c_maske[0];
            i1.gecerli = akt[1]; i1.adres = c_adres[1]; i1.yaz = c_yaz[1];
            i1.veri = c_veri[1]; i1.maske = c_maske[1];
            i0.yan_hazir = ($urandom_range(3) != 0);
            i1.yan_hazir = ($urandom_range(3) != 0);
            p.hazir = ($urandom_range(3) != 0);
            if (!yanit && l1_q.size() > 0 && $urandom_range(1) == 0)
                yanit = 1;
            p.yan_gecerli = yanit;
            p.yan_veri = yanit ? hsh(l1_q[0]) : $urandom;
        end
        chk("rnd_aclik", enuzun < 200, 1);
        chk("rnd_hata", hata, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
